// File: rtl/muldiv_sequencer.sv
// Multi-cycle sequencer for M-extension ALU ops: handshake, operand hold, fast cases, flush.
// Optional build macro MULDIV_RESULT_CACHE_EN adds a single-entry result cache.
module muldiv_sequencer #(
  parameter int unsigned MUL_LAT = 3,
  parameter int unsigned DIV_LAT = 8
) (
  input  logic        CLK,
  input  logic        RESETN,
  input  logic        FLUSH,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic [4:0]  REQ_SELECT,
  input  logic [31:0] REQ_DATA1,
  input  logic [31:0] REQ_DATA2,
  input  logic [4:0]  REQ_TAG,
  output logic [4:0]  ALU_SELECT,
  output logic [31:0] ALU_DATA1,
  output logic [31:0] ALU_DATA2,
  input  logic [31:0] ALU_RESULT,
  output logic        RESP_VALID,
  input  logic        RESP_READY,
  output logic [31:0] RESP_RESULT,
  output logic [4:0]  RESP_TAG,
  output logic        RESP_ERR,
  output logic        BUSY
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t      state;
  logic [5:0]  cnt;
  logic [4:0]  sel_q;
  logic [31:0] d1_q, d2_q;
  logic [4:0]  tag_q;
  logic        err_q;
  logic        from_exec;
  logic [31:0] fast_q;

  logic        accept, legal, is_div, is_rem, signed_op, div_zero, div_ovf;
  logic        fast_hit;
  logic [31:0] fast_res;

`ifdef MULDIV_RESULT_CACHE_EN
  logic        cache_vld;
  logic [4:0]  c_sel;
  logic [31:0] c_d1, c_d2, c_res;
`endif

  assign REQ_READY = (state == IDLE) && !FLUSH;
  assign accept    = REQ_VALID && REQ_READY;
  assign legal     = (REQ_SELECT[4:3] == 2'b01);
  assign is_div    = REQ_SELECT[2];
  assign is_rem    = REQ_SELECT[1];
  assign signed_op = !REQ_SELECT[0];
  assign div_zero  = legal && is_div && (REQ_DATA2 == '0);
  assign div_ovf   = legal && is_div && signed_op &&
                     (REQ_DATA1 == 32'h8000_0000) && (REQ_DATA2 == '1);

  always_comb begin
    fast_hit = 1'b1;
    fast_res = '0;
    if (!legal)        fast_res = '0;
    else if (div_zero) fast_res = is_rem ? REQ_DATA1 : '1;
    else if (div_ovf)  fast_res = is_rem ? '0 : 32'h8000_0000;
`ifdef MULDIV_RESULT_CACHE_EN
    else if (cache_vld && ({REQ_SELECT, REQ_DATA1, REQ_DATA2} == {c_sel, c_d1, c_d2}))
      fast_res = c_res;
`endif
    else fast_hit = 1'b0;
  end

  // Outputs lag the state by one edge: ALU_* are driven for the LAT cycles after
  // each EXEC edge, and RESP_VALID/RESP_RESULT are loaded on the first RESP edge,
  // which is also the last edge the ALU operands are held.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state       <= IDLE;
      cnt         <= '0;
      sel_q       <= '0;
      d1_q        <= '0;
      d2_q        <= '0;
      tag_q       <= '0;
      err_q       <= 1'b0;
      from_exec   <= 1'b0;
      fast_q      <= '0;
      ALU_SELECT  <= '0;
      ALU_DATA1   <= '0;
      ALU_DATA2   <= '0;
      RESP_VALID  <= 1'b0;
      RESP_RESULT <= '0;
      RESP_TAG    <= '0;
      RESP_ERR    <= 1'b0;
      BUSY        <= 1'b0;
`ifdef MULDIV_RESULT_CACHE_EN
      cache_vld   <= 1'b0;
      c_sel       <= '0;
      c_d1        <= '0;
      c_d2        <= '0;
      c_res       <= '0;
`endif
    end else if (FLUSH) begin
      state      <= IDLE;
      cnt        <= '0;
      ALU_SELECT <= '0;
      ALU_DATA1  <= '0;
      ALU_DATA2  <= '0;
      RESP_VALID <= 1'b0;
      BUSY       <= 1'b0;
`ifdef MULDIV_RESULT_CACHE_EN
      cache_vld  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          ALU_SELECT <= '0;
          ALU_DATA1  <= '0;
          ALU_DATA2  <= '0;
          if (accept) begin
            sel_q <= REQ_SELECT;
            d1_q  <= REQ_DATA1;
            d2_q  <= REQ_DATA2;
            tag_q <= REQ_TAG;
            err_q <= !legal;
            BUSY  <= 1'b1;
            if (fast_hit) begin
              state     <= RESP;
              fast_q    <= fast_res;
              from_exec <= 1'b0;
            end else begin
              state     <= EXEC;
              from_exec <= 1'b1;
              cnt       <= is_div ? 6'(DIV_LAT - 1) : 6'(MUL_LAT - 1);
            end
          end
        end
        EXEC: begin
          ALU_SELECT <= sel_q;
          ALU_DATA1  <= d1_q;
          ALU_DATA2  <= d2_q;
          if (cnt == '0) state <= RESP;
          else           cnt   <= cnt - 6'd1;
        end
        RESP: begin
          ALU_SELECT <= '0;
          ALU_DATA1  <= '0;
          ALU_DATA2  <= '0;
          if (!RESP_VALID) begin
            RESP_VALID  <= 1'b1;
            RESP_RESULT <= from_exec ? ALU_RESULT : fast_q;
            RESP_TAG    <= tag_q;
            RESP_ERR    <= err_q;
`ifdef MULDIV_RESULT_CACHE_EN
            if (from_exec) begin
              cache_vld <= 1'b1;
              c_sel     <= sel_q;
              c_d1      <= d1_q;
              c_d2      <= d2_q;
              c_res     <= ALU_RESULT;
            end
`endif
          end else if (RESP_READY) begin
            RESP_VALID <= 1'b0;
            state      <= IDLE;
            BUSY       <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer with a latency-aware ALU model and a response scoreboard.
`timescale 1ns/1ps
module tb_muldiv_sequencer;

  logic        CLK = 1'b0;
  logic        RESETN = 1'b0;
  logic        FLUSH = 1'b0;
  logic        REQ_VALID = 1'b0;
  logic        REQ_READY;
  logic [4:0]  REQ_SELECT = '0;
  logic [31:0] REQ_DATA1 = '0;
  logic [31:0] REQ_DATA2 = '0;
  logic [4:0]  REQ_TAG = '0;
  logic [4:0]  ALU_SELECT;
  logic [31:0] ALU_DATA1, ALU_DATA2;
  logic [31:0] ALU_RESULT;
  logic        RESP_VALID;
  logic        RESP_READY = 1'b0;
  logic [31:0] RESP_RESULT;
  logic [4:0]  RESP_TAG;
  logic        RESP_ERR;
  logic        BUSY;

  muldiv_sequencer #(.MUL_LAT(3), .DIV_LAT(8)) dut (
    .CLK(CLK), .RESETN(RESETN), .FLUSH(FLUSH),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_SELECT(REQ_SELECT),
    .REQ_DATA1(REQ_DATA1), .REQ_DATA2(REQ_DATA2), .REQ_TAG(REQ_TAG),
    .ALU_SELECT(ALU_SELECT), .ALU_DATA1(ALU_DATA1), .ALU_DATA2(ALU_DATA2),
    .ALU_RESULT(ALU_RESULT), .RESP_VALID(RESP_VALID), .RESP_READY(RESP_READY),
    .RESP_RESULT(RESP_RESULT), .RESP_TAG(RESP_TAG), .RESP_ERR(RESP_ERR), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

`ifdef MULDIV_RESULT_CACHE_EN
  localparam int unsigned REPEAT_LAT = 1;
`else
  localparam int unsigned REPEAT_LAT = 4;
`endif

  typedef struct {
    logic [4:0]  tag;
    logic [31:0] res;
    logic        err;
    int unsigned lat;
    int unsigned n;
  } sb_t;

  sb_t         sbq[$];
  int unsigned cyc = 0;
  int unsigned total = 0;
  int unsigned bad = 0;
  int unsigned alu_mul_cycles = 0;
  logic [5:0]  alu_age = '0;

  always @(posedge CLK) cyc <= cyc + 1;
  always @(negedge CLK) if (ALU_SELECT == 5'b01000) alu_mul_cycles <= alu_mul_cycles + 1;

  // ALU reference: garbage until operands have been held for the op's latency.
  function automatic logic [31:0] alu_f(input logic [4:0] s, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] p;
    case (s[2:0])
      3'b000: p = $signed({32'b0, a}) * $signed({32'b0, b});
      3'b001: p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
      3'b010: p = $signed({{32{a[31]}}, a}) * $signed({32'b0, b});
      3'b011: p = $signed({32'b0, a}) * $signed({32'b0, b});
      default: p = '0;
    endcase
    if (!s[2]) return (s[1:0] == 2'b00) ? p[31:0] : p[63:32];
    if (b == 0) return '1;
    case (s[1:0])
      2'b00:   return $signed(a) / $signed(b);
      2'b01:   return a / b;
      2'b10:   return $signed(a) % $signed(b);
      default: return a % b;
    endcase
  endfunction

  always @(posedge CLK) alu_age <= (ALU_SELECT != '0) ? alu_age + 6'd1 : '0;

  always_comb begin
    ALU_RESULT = 32'hDEAD_BEEF;
    if (int'(alu_age) + 1 >= (ALU_SELECT[2] ? 8 : 3))
      ALU_RESULT = alu_f(ALU_SELECT, ALU_DATA1, ALU_DATA2);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [4:0] s, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] t, input logic [31:0] er, input logic ee,
                      input int unsigned el);
    sb_t it;
    int  k = 0;
    REQ_SELECT = s; REQ_DATA1 = a; REQ_DATA2 = b; REQ_TAG = t; REQ_VALID = 1'b1;
    while (REQ_READY !== 1'b1 && k < 20) begin @(negedge CLK); k++; end
    check("req_ready", 32'(REQ_READY), 32'd1);
    @(posedge CLK); @(negedge CLK);
    REQ_VALID = 1'b0;
    it = '{t, er, ee, el, cyc};
    sbq.push_back(it);
  endtask

  task automatic wait_resp(input int budget, input int hold);
    sb_t it;
    int  k = 0;
    while (RESP_VALID !== 1'b1 && k < budget) begin @(negedge CLK); k++; end
    check("resp_seen", 32'(RESP_VALID), 32'd1);
    check("sb_depth", 32'(sbq.size()), 32'd1);
    if (RESP_VALID === 1'b1 && sbq.size() > 0) begin
      it = sbq.pop_front();
      check("latency", cyc - it.n, it.lat);
      check("result", RESP_RESULT, it.res);
      check("tag", 32'(RESP_TAG), 32'(it.tag));
      check("err", 32'(RESP_ERR), 32'(it.err));
      for (int h = 0; h < hold; h++) begin
        @(negedge CLK);
        check("hold_valid", 32'(RESP_VALID), 32'd1);
        check("hold_result", RESP_RESULT, it.res);
        check("hold_tag", 32'(RESP_TAG), 32'(it.tag));
        check("hold_busy", 32'(BUSY), 32'd1);
        check("hold_req_ready", 32'(REQ_READY), 32'd0);
      end
      RESP_READY = 1'b1;
      @(negedge CLK);
      RESP_READY = 1'b0;
      check("post_hs_valid", 32'(RESP_VALID), 32'd0);
      check("post_hs_req_ready", 32'(REQ_READY), 32'd1);
    end
  endtask

  task automatic watch_quiet(input string tag, input int n);
    int seen = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      if (RESP_VALID !== 1'b0) seen++;
    end
    check(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "global timeout");
  end

  initial begin
    sb_t         it;
    int unsigned m0;

    repeat (2) @(negedge CLK);
    check("rst_resp_valid", 32'(RESP_VALID), 32'd0);
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_alu_sel", 32'(ALU_SELECT), 32'd0);
    check("rst_result", RESP_RESULT, 32'd0);
    check("rst_tag", 32'(RESP_TAG), 32'd0);
    check("rst_err", 32'(RESP_ERR), 32'd0);
    RESETN = 1'b1;
    @(negedge CLK);
    check("rst_req_ready", 32'(REQ_READY), 32'd1);

    // MUL 25*20, ALU operands held for exactly MUL_LAT cycles
    m0 = alu_mul_cycles;
    send(5'b01000, 32'd25, 32'd20, 5'd3, 32'd500, 1'b0, 4);
    check("busy_exec", 32'(BUSY), 32'd1);
    wait_resp(20, 0);
    check("alu_mul_cycles", alu_mul_cycles - m0, 32'd3);

    send(5'b01000, 32'd25, 32'd20, 5'd4, 32'd500, 1'b0, REPEAT_LAT);
    wait_resp(20, 0);
    send(5'b01000, 32'd25, 32'd21, 5'd5, 32'd525, 1'b0, 4);
    wait_resp(20, 0);

    // Divide path and RISC-V corner cases
    send(5'b01100, 32'd100, 32'd7, 5'd6, 32'd14, 1'b0, 9);            wait_resp(20, 0);
    send(5'b01100, 32'd5, 32'd0, 5'd7, 32'hFFFF_FFFF, 1'b0, 1);       wait_resp(20, 0);
    send(5'b01110, 32'd5, 32'd0, 5'd8, 32'd5, 1'b0, 1);               wait_resp(20, 0);
    send(5'b01101, 32'd9, 32'd0, 5'd9, 32'hFFFF_FFFF, 1'b0, 1);       wait_resp(20, 0);
    send(5'b01111, 32'd9, 32'd0, 5'd10, 32'd9, 1'b0, 1);              wait_resp(20, 0);
    send(5'b01100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 1'b0, 1); wait_resp(20, 0);
    send(5'b01110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'd0, 1'b0, 1);         wait_resp(20, 0);
    send(5'b01101, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'd0, 1'b0, 9);         wait_resp(20, 0);
    send(5'b01100, 32'hFFFF_FFEC, 32'd3, 5'd14, 32'hFFFF_FFFA, 1'b0, 9);         wait_resp(20, 0);
    send(5'b01110, 32'hFFFF_FFEC, 32'd3, 5'd15, 32'hFFFF_FFFE, 1'b0, 9);         wait_resp(20, 0);
    send(5'b01111, 32'd100, 32'd7, 5'd16, 32'd2, 1'b0, 9);            wait_resp(20, 0);
    send(5'b01001, 32'hFFFF_FFFD, 32'd7, 5'd17, 32'hFFFF_FFFF, 1'b0, 4);         wait_resp(20, 0);
    send(5'b01011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd18, 32'hFFFF_FFFE, 1'b0, 4); wait_resp(20, 0);

    // Illegal SELECT codes
    send(5'b00000, 32'd1, 32'd2, 5'd19, 32'd0, 1'b1, 1);              wait_resp(20, 0);
    send(5'b10000, 32'd1, 32'd2, 5'd20, 32'd0, 1'b1, 1);              wait_resp(20, 0);

    // Backpressure, with a queued request that must wait for the handshake
    send(5'b01000, 32'd7, 32'd6, 5'd21, 32'd42, 1'b0, 4);
    REQ_SELECT = 5'b01000; REQ_DATA1 = 32'd6; REQ_DATA2 = 32'd9; REQ_TAG = 5'd22; REQ_VALID = 1'b1;
    wait_resp(20, 5);
    @(posedge CLK); @(negedge CLK);
    REQ_VALID = 1'b0;
    check("reaccept_busy", 32'(BUSY), 32'd1);
    it = '{5'd22, 32'd54, 1'b0, 4, cyc};
    sbq.push_back(it);
    wait_resp(20, 0);

    // FLUSH in DIV EXEC cycle 2
    send(5'b01100, 32'd1000, 32'd10, 5'd23, 32'd100, 1'b0, 9);
    void'(sbq.pop_back());
    @(negedge CLK);
    FLUSH = 1'b1;
    @(negedge CLK);
    check("flush_busy", 32'(BUSY), 32'd0);
    check("flush_alu_sel", 32'(ALU_SELECT), 32'd0);
    FLUSH = 1'b0;
    #1;
    check("flush_req_ready", 32'(REQ_READY), 32'd1);
    watch_quiet("flush_no_resp", 14);

    // FLUSH together with REQ_VALID
    REQ_SELECT = 5'b01000; REQ_DATA1 = 32'd3; REQ_DATA2 = 32'd3; REQ_TAG = 5'd24;
    FLUSH = 1'b1; REQ_VALID = 1'b1;
    @(negedge CLK);
    check("flush_req_busy", 32'(BUSY), 32'd0);
    FLUSH = 1'b0; REQ_VALID = 1'b0;
    watch_quiet("flush_req_no_resp", 8);

    send(5'b01000, 32'd25, 32'd21, 5'd25, 32'd525, 1'b0, 4);
    wait_resp(20, 0);

    // Reset during EXEC
    send(5'b01100, 32'd100, 32'd3, 5'd26, 32'd33, 1'b0, 9);
    void'(sbq.pop_back());
    repeat (3) @(negedge CLK);
    RESETN = 1'b0;
    #1;
    check("mid_rst_busy", 32'(BUSY), 32'd0);
    check("mid_rst_alu_sel", 32'(ALU_SELECT), 32'd0);
    check("mid_rst_alu_d1", ALU_DATA1, 32'd0);
    check("mid_rst_valid", 32'(RESP_VALID), 32'd0);
    check("mid_rst_result", RESP_RESULT, 32'd0);
    check("mid_rst_tag", 32'(RESP_TAG), 32'd0);
    check("mid_rst_req_ready", 32'(REQ_READY), 32'd1);
    @(negedge CLK);
    RESETN = 1'b1;
    watch_quiet("rst_no_resp", 12);

    send(5'b01000, 32'd25, 32'd20, 5'd27, 32'd500, 1'b0, 4);
    wait_resp(20, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
